// File: rtl/ps2_mouse_cmd_tx_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, mouse command bytes
// and the parity helper used when a command is latched.
package ps2_mouse_cmd_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_REQ       = 3'd2,
        ST_SEND      = 3'd3,
        ST_ACK       = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } ps2_tx_state_t;

    localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;  // enable data reporting
    localparam logic [7:0] PS2_CMD_DISABLE = 8'hF5;  // disable data reporting
    localparam logic [7:0] PS2_ACK_BYTE    = 8'hFA;  // mouse reply, checked by the receiver

    // Index of the last device clock fall of the frame (presents the stop bit).
    localparam logic [3:0] PS2_STOP_IDX = 4'd9;
    localparam logic [3:0] PS2_PAR_IDX  = 4'd8;

    // PS/2 frames carry odd parity: the parity bit makes the total count of ones odd.
    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_mouse_cmd_tx_line_sync.sv
// Two-flop synchronizers for the raw PS/2 clock and data lines plus a
// registered one-cycle pulse on each falling edge of the synced clock.
// The mouse receiver instantiates this block as well.
module ps2_mouse_cmd_tx_line_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic ps2_clk_in,
    input  logic ps2_dat_in,
    output logic clk_sync,
    output logic dat_sync,
    output logic fall
);
    import ps2_mouse_cmd_tx_pkg::*;

    logic clk_meta;
    logic dat_meta;
    logic clk_prev;

    // Synchronize both lines; reset to the idle (high) level so no false edge
    // is seen right after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_meta <= 1'b1;
            clk_sync <= 1'b1;
            clk_prev <= 1'b1;
            dat_meta <= 1'b1;
            dat_sync <= 1'b1;
            fall     <= 1'b0;
        end else begin
            clk_meta <= ps2_clk_in;
            clk_sync <= clk_meta;
            clk_prev <= clk_sync;
            dat_meta <= ps2_dat_in;
            dat_sync <= dat_meta;
            fall     <= clk_prev & ~clk_sync;
        end
    end

endmodule

// File: rtl/ps2_mouse_cmd_tx.sv
// PS/2 host-to-mouse command transmitter. Sends 0xF4/0xF5 over the
// open-drain clock/data pair, checks the line-level ACK bit and reports
// done or error. oInhibitRx keeps the mouse receiver off the line meanwhile.
module ps2_mouse_cmd_tx
    import ps2_mouse_cmd_tx_pkg::*;
#(
    parameter int         INHIBIT_CYCLES = 6000,
    parameter int         TIMEOUT_CYCLES = 750000,
    parameter logic [7:0] CMD_ENABLE     = PS2_CMD_ENABLE,
    parameter logic [7:0] CMD_DISABLE    = PS2_CMD_DISABLE
) (
    input  logic iClk,
    input  logic iResetn,
    input  logic iStart,
    input  logic iEnable,
    input  logic iPs2ClkIn,
    input  logic iPs2DatIn,
    output logic oPs2ClkOe,
    output logic oPs2DatOe,
    output logic oBusy,
    output logic oInhibitRx,
    output logic oDone,
    output logic oError
);
    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IW-1:0] INHIBIT_LAST = IW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    ps2_tx_state_t  state;
    logic [7:0]     cmd;
    logic           parity;
    logic [IW-1:0]  inhibit_cnt;
    logic [TW-1:0]  timeout_cnt;
    logic [3:0]     bit_idx;
    logic           clk_sync;
    logic           dat_sync;
    logic           fall;
    logic           timeout_hit;

    ps2_mouse_cmd_tx_line_sync u_line_sync (
        .clk        (iClk),
        .rst_n      (iResetn),
        .ps2_clk_in (iPs2ClkIn),
        .ps2_dat_in (iPs2DatIn),
        .clk_sync   (clk_sync),
        .dat_sync   (dat_sync),
        .fall       (fall)
    );

    // The timeout cycle is the one in which the counter would reach TIMEOUT_CYCLES.
    assign timeout_hit = (timeout_cnt == TIMEOUT_LAST);
    assign oInhibitRx  = oBusy;

    // Transmit FSM with registered line enables, busy flag and result pulses.
    always_ff @(posedge iClk or negedge iResetn) begin
        if (!iResetn) begin
            state       <= ST_IDLE;
            cmd         <= 8'h00;
            parity      <= 1'b0;
            inhibit_cnt <= '0;
            timeout_cnt <= '0;
            bit_idx     <= 4'd0;
            oPs2ClkOe   <= 1'b0;
            oPs2DatOe   <= 1'b0;
            oBusy       <= 1'b0;
            oDone       <= 1'b0;
            oError      <= 1'b0;
        end else begin
            oDone  <= 1'b0;
            oError <= 1'b0;
            case (state)
                ST_IDLE: begin
                    oPs2ClkOe <= 1'b0;
                    oPs2DatOe <= 1'b0;
                    oBusy     <= 1'b0;
                    if (iStart) begin
                        cmd         <= iEnable ? CMD_ENABLE : CMD_DISABLE;
                        parity      <= odd_parity(iEnable ? CMD_ENABLE : CMD_DISABLE);
                        inhibit_cnt <= '0;
                        oPs2ClkOe   <= 1'b1;
                        oBusy       <= 1'b1;
                        state       <= ST_INHIBIT;
                    end
                end
                ST_INHIBIT: begin
                    if (inhibit_cnt == INHIBIT_LAST) begin
                        oPs2DatOe <= 1'b1;  // start bit, clock still held low
                        state     <= ST_REQ;
                    end else begin
                        inhibit_cnt <= inhibit_cnt + IW'(1);
                    end
                end
                ST_REQ: begin
                    // Release the clock; data stays low as the start bit until the first fall.
                    oPs2ClkOe   <= 1'b0;
                    bit_idx     <= 4'd0;
                    timeout_cnt <= '0;
                    state       <= ST_SEND;
                end
                ST_SEND, ST_ACK, ST_WAIT_IDLE: begin
                    if (timeout_hit) begin
                        oPs2ClkOe <= 1'b0;
                        oPs2DatOe <= 1'b0;
                        oBusy     <= 1'b0;
                        oError    <= 1'b1;
                        state     <= ST_IDLE;
                    end else begin
                        timeout_cnt <= timeout_cnt + TW'(1);
                        if (state == ST_SEND) begin
                            if (fall) begin
                                bit_idx <= bit_idx + 4'd1;
                                if (bit_idx == PS2_STOP_IDX) begin
                                    oPs2DatOe <= 1'b0;  // stop bit: release data
                                    state     <= ST_ACK;
                                end else if (bit_idx == PS2_PAR_IDX) begin
                                    oPs2DatOe <= ~parity;
                                end else begin
                                    oPs2DatOe <= ~cmd[bit_idx[2:0]];
                                end
                            end
                        end else if (state == ST_ACK) begin
                            if (fall) begin
                                if (dat_sync) begin
                                    oBusy  <= 1'b0;
                                    oError <= 1'b1;
                                    state  <= ST_IDLE;
                                end else begin
                                    state <= ST_WAIT_IDLE;
                                end
                            end
                        end else begin
                            if (clk_sync && dat_sync) begin
                                oBusy <= 1'b0;
                                oDone <= 1'b1;
                                state <= ST_IDLE;
                            end
                        end
                    end
                end
                default: begin
                    oPs2ClkOe <= 1'b0;
                    oPs2DatOe <= 1'b0;
                    oBusy     <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_mouse_cmd_tx.sv
// Bench for ps2_mouse_cmd_tx: a behavioural PS/2 mouse drives the open-drain
// lines with a 40-cycle clock, table-driven transactions check the frame bits
// and results, and hand-written sequences cover timeout, ignored restart and
// mid-frame reset.
module tb_ps2_mouse_cmd_tx;

    localparam int INHIBIT = 10;
    localparam int TIMEOUT = 2000;
    localparam int HALF    = 20;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic enable = 1'b0;
    logic dev_clk = 1'b1;
    logic dev_dat = 1'b1;
    logic clk_oe, dat_oe, busy, inhibit_rx, done, error;
    logic line_clk, line_dat;

    int n_cmp = 0;
    int n_bad = 0;
    int n_done = 0;
    int n_err = 0;
    int n_both = 0;

    typedef struct {
        logic       en;
        logic       ack;
        logic [7:0] exp_byte;
        logic       exp_par;
        int         exp_done;
        int         exp_err;
    } vec_t;

    vec_t vecs[4];

    // Open-drain wired-AND of host and device on both lines.
    assign line_clk = ~clk_oe & dev_clk;
    assign line_dat = ~dat_oe & dev_dat;

    ps2_mouse_cmd_tx #(
        .INHIBIT_CYCLES (INHIBIT),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .iClk       (clk),
        .iResetn    (rst_n),
        .iStart     (start),
        .iEnable    (enable),
        .iPs2ClkIn  (line_clk),
        .iPs2DatIn  (line_dat),
        .oPs2ClkOe  (clk_oe),
        .oPs2DatOe  (dat_oe),
        .oBusy      (busy),
        .oInhibitRx (inhibit_rx),
        .oDone      (done),
        .oError     (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock and sample just after the edge, tallying result pulses.
    task automatic step();
        @(posedge clk);
        #1;
        if (done) n_done++;
        if (error) n_err++;
        if (done && error) n_both++;
    endtask

    task automatic run_txn(input logic en, input logic ack, input logic [7:0] exp_byte,
                           input logic exp_par, input int exp_done, input int exp_err,
                           input bit flip_start);
        int cnt;
        logic [7:0] got_byte;
        logic got_par;
        logic got_stop;
        n_done = 0;
        n_err  = 0;
        n_both = 0;
        got_byte = 8'h00;
        got_par  = 1'b0;
        got_stop = 1'b0;
        start  = 1'b1;
        enable = en;
        step();
        start  = 1'b0;
        check("busy_inhibit_rx", {30'd0, busy, inhibit_rx}, 32'h3);
        cnt = 0;
        while (clk_oe && !dat_oe && cnt < 100) begin
            cnt++;
            step();
        end
        check("inhibit_len", cnt, INHIBIT);
        check("req_both_oe", {30'd0, clk_oe, dat_oe}, 32'h3);
        step();
        check("send_entry_oe", {30'd0, clk_oe, dat_oe}, 32'h1);
        repeat (HALF) step();
        for (int k = 1; k <= 11; k++) begin
            dev_clk = 1'b0;
            repeat (HALF - 1) step();
            if (k <= 8) got_byte[k-1] = line_dat;
            else if (k == 9) got_par = line_dat;
            else if (k == 10) got_stop = line_dat;
            step();
            dev_clk = 1'b1;
            if (k == 10 && ack) dev_dat = 1'b0;
            if (k == 11) dev_dat = 1'b1;
            repeat (HALF) step();
            if (flip_start && k == 4) begin
                start  = 1'b1;
                enable = ~en;
                step();
                start  = 1'b0;
            end
        end
        cnt = 0;
        while (busy && cnt < 200) begin
            cnt++;
            step();
        end
        check("byte", {24'd0, got_byte}, {24'd0, exp_byte});
        check("parity", {31'd0, got_par}, {31'd0, exp_par});
        check("stop", {31'd0, got_stop}, 32'h1);
        check("busy_clear", {31'd0, busy}, 32'h0);
        check("lines_released", {30'd0, clk_oe, dat_oe}, 32'h0);
        check("done_count", n_done, exp_done);
        check("error_count", n_err, exp_err);
        check("done_error_overlap", n_both, 0);
        repeat (10) step();
    endtask

    initial begin
        vecs[0] = '{en: 1'b1, ack: 1'b1, exp_byte: 8'hF4, exp_par: 1'b0, exp_done: 1, exp_err: 0};
        vecs[1] = '{en: 1'b0, ack: 1'b1, exp_byte: 8'hF5, exp_par: 1'b1, exp_done: 1, exp_err: 0};
        vecs[2] = '{en: 1'b1, ack: 1'b0, exp_byte: 8'hF4, exp_par: 1'b0, exp_done: 0, exp_err: 1};
        vecs[3] = '{en: 1'b0, ack: 1'b0, exp_byte: 8'hF5, exp_par: 1'b1, exp_done: 0, exp_err: 1};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {26'd0, clk_oe, dat_oe, busy, inhibit_rx, done, error}, 32'h0);
        rst_n = 1'b1;
        repeat (5) step();
        check("idle_outputs", {26'd0, clk_oe, dat_oe, busy, inhibit_rx, done, error}, 32'h0);

        // Table-driven transactions
        for (int i = 0; i < 4; i++) begin
            run_txn(vecs[i].en, vecs[i].ack, vecs[i].exp_byte, vecs[i].exp_par,
                    vecs[i].exp_done, vecs[i].exp_err, 1'b0);
        end

        // Restart request mid-SEND with the enable flipped must be ignored
        run_txn(1'b1, 1'b1, 8'hF4, 1'b0, 1, 0, 1'b1);

        // Device never clocks: timeout counted from SEND entry
        begin
            int cnt;
            n_done = 0;
            n_err  = 0;
            start  = 1'b1;
            enable = 1'b1;
            step();
            start  = 1'b0;
            cnt = 0;
            while (clk_oe && cnt < 100) begin
                cnt++;
                step();
            end
            cnt = 0;
            while (!error && cnt < 3000) begin
                step();
                cnt++;
            end
            check("timeout_cycles", cnt, TIMEOUT);
            check("timeout_lines", {30'd0, clk_oe, dat_oe}, 32'h0);
            step();
            check("timeout_busy", {31'd0, busy}, 32'h0);
            repeat (10) step();
            check("timeout_error_count", n_err, 1);
            check("timeout_done_count", n_done, 0);
        end

        // Reset asserted while bit 4 is on the line
        begin
            int cnt;
            n_done = 0;
            n_err  = 0;
            start  = 1'b1;
            enable = 1'b1;
            step();
            start  = 1'b0;
            cnt = 0;
            while (clk_oe && cnt < 100) begin
                cnt++;
                step();
            end
            repeat (HALF) step();
            for (int k = 1; k <= 4; k++) begin
                dev_clk = 1'b0;
                repeat (HALF) step();
                if (k < 4) begin
                    dev_clk = 1'b1;
                    repeat (HALF) step();
                end
            end
            check("rst_pre_bit4", {30'd0, clk_oe, dat_oe}, 32'h1);
            #3;
            rst_n = 1'b0;
            #1;
            check("rst_async_release", {30'd0, clk_oe, dat_oe}, 32'h0);
            check("rst_no_pulse_now", {30'd0, done, error}, 32'h0);
            dev_clk = 1'b1;
            repeat (5) step();
            rst_n = 1'b1;
            repeat (5) step();
            check("rst_no_pulses", n_done + n_err, 0);
            check("rst_busy", {31'd0, busy}, 32'h0);
        end
        run_txn(1'b1, 1'b1, 8'hF4, 1'b0, 1, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ps2_mouse_cmd_tx.md
Name: ps2_mouse_cmd_tx

Overview:
- PS/2 host-to-mouse command transmitter; the responder to the drawing control path's mouse enable/disable request (start-transmission strobe plus enable-mouse level).
- Sends 0xF4 (enable data reporting) or 0xF5 (disable) over the open-drain PS/2 clock/data pair.
- Checks the device line-level ACK bit and reports done or error.
- Sits between the drawing control path and the PS/2 pins, alongside the mouse receiver, which it holds off while transmitting.

Parameters:
INHIBIT_CYCLES, 6000, clock-low inhibit time in iClk cycles (120 us at 50 MHz)
TIMEOUT_CYCLES, 750000, max cycles from clock release to transaction end (15 ms at 50 MHz)
CMD_ENABLE, 8'hF4, command byte sent when iEnable=1
CMD_DISABLE, 8'hF5, command byte sent when iEnable=0

Ports:
iClk  input  1  system clock
iResetn  input  1  reset; asynchronous, active-low
iStart  input  1  request to send; sampled only in IDLE
iEnable  input  1  1 selects CMD_ENABLE, 0 selects CMD_DISABLE; latched with iStart
iPs2ClkIn  input  1  raw PS/2 clock line level (asynchronous)
iPs2DatIn  input  1  raw PS/2 data line level (asynchronous)
oPs2ClkOe  output  1  1 = drive PS/2 clock low, 0 = release
oPs2DatOe  output  1  1 = drive PS/2 data low, 0 = release
oBusy  output  1  high in every state except IDLE
oInhibitRx  output  1  equals oBusy; receiver ignores the line while high
oDone  output  1  one-cycle pulse: command accepted (ACK low)
oError  output  1  one-cycle pulse: NACK or timeout

Behaviour:
- Clock and reset: one clock, iClk; reset iResetn is asynchronous and active-low.
- Reset values: all outputs 0, both lines released, state IDLE.
  - Asserting reset mid-transaction releases both lines immediately (asynchronously) and produces no oDone/oError pulse.
- Line sampling:
  - iPs2ClkIn and iPs2DatIn each pass through a 2-flop synchronizer.
  - fall = previous synced clock 1 AND current synced clock 0; registered, one-cycle pulse.
- Command latch:
  - In IDLE with iStart=1: latch cmd = iEnable ? CMD_ENABLE : CMD_DISABLE.
  - Latch parity = ~^cmd (odd parity). Go to INHIBIT.
  - iStart while busy is ignored; there is no queueing.
- States:
  - IDLE: both Oe=0.
  - INHIBIT: oPs2ClkOe=1 for exactly INHIBIT_CYCLES cycles, then REQ.
  - REQ: oPs2ClkOe=1, oPs2DatOe=1 (start bit) for one cycle, then SEND. Clear bit index and timeout counter.
  - SEND:
    - oPs2ClkOe=0; data line holds the current bit, with oPs2DatOe = ~bit.
    - On each fall, advance the bit: edges 1-8 present cmd[0]..cmd[7] (LSB first), edge 9 presents parity, edge 10 presents stop (release).
    - After edge 10, go to ACK.
  - ACK:
    - Lines released. On the next fall, sample synced data.
    - 0: go to WAIT_IDLE.
    - 1: pulse oError and go to IDLE.
  - WAIT_IDLE: wait until synced clock=1 AND synced data=1 in the same cycle, then pulse oDone and go to IDLE.
- Timeout:
  - Counter runs in SEND, ACK and WAIT_IDLE.
  - Reaching TIMEOUT_CYCLES releases both lines, pulses oError and returns to IDLE.
  - Timeout wins over a simultaneous fall.
- Counter widths: $clog2(max+1) for each counter; no wrap-around (counters saturate/stop at terminal count).
- oDone and oError are mutually exclusive and never exceed one cycle.
  - iStart may be sampled in the same cycle oBusy falls only from the following cycle (IDLE entry).

Decomposition:
- Shared package/include ps2_defs: state encodings (IDLE..WAIT_IDLE) and command constants 8'hF4, 8'hF5, 8'hFA (ACK byte, used by the receiver).
- One sub-module ps2_line_sync: 2-flop synchronizer for clock and data plus registered falling-edge pulse. The mouse receiver reuses it.

Test Plan:
(bench overrides INHIBIT_CYCLES=10, TIMEOUT_CYCLES=2000; device model clocks at 40-cycle period)
- iStart=1, iEnable=1, model ACKs:
  - oPs2ClkOe high exactly 10 cycles, then one cycle with both Oe=1.
  - Data bits after falls: 0,0,1,0,1,1,1,1, parity 0, stop released.
  - oDone pulses once after lines idle; oError stays 0.
- iStart=1, iEnable=0: byte 0xF5 seen as 1,0,1,0,1,1,1,1; parity bit 1; oDone pulses.
- Model leaves data high at the 11th fall: oError pulses once, no oDone, oBusy=0 next cycle.
- Model never clocks after REQ: oError pulses exactly 2000 cycles after SEND entry; both Oe=0.
- iStart pulsed again mid-SEND with iEnable flipped: ignored; the transmitted byte remains the first command.
- iResetn low during bit 4: both Oe=0 in the same cycle, no pulses; a fresh iStart after release completes normally.
